// File: rtl/ula_pkg.sv
// Shared types for the nibble-serial ALU: sequencer state encoding and default slice count.
package ula_pkg;

    localparam int N_NIB_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/module_ula_74181.sv
// One 4-bit 74181-style ALU slice with active-high data and active-high carry (c=1 adds one).
// a_eq_b follows the classic part: it flags F == 4'hF, which means A == B under sel=0110, mode=0, c_in=0.
module module_ula_74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] sel,
    input  logic       mode,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out,
    output logic       a_eq_b
);

    logic [3:0] add_x;
    logic [3:0] add_y;
    logic [4:0] sum;
    logic [3:0] logic_f;

    // Every arithmetic function is expressed as add_x + add_y + c_in, so carry-out is bit 4 of the sum.
    always_comb begin
        add_x = a;
        add_y = 4'h0;
        unique case (sel)
            4'b0000: begin add_x = a;        add_y = 4'h0;    end
            4'b0001: begin add_x = a | b;    add_y = 4'h0;    end
            4'b0010: begin add_x = a | ~b;   add_y = 4'h0;    end
            4'b0011: begin add_x = 4'h0;     add_y = 4'hF;    end
            4'b0100: begin add_x = a;        add_y = a & ~b;  end
            4'b0101: begin add_x = a | b;    add_y = a & ~b;  end
            4'b0110: begin add_x = a;        add_y = ~b;      end
            4'b0111: begin add_x = a & ~b;   add_y = 4'hF;    end
            4'b1000: begin add_x = a;        add_y = a & b;   end
            4'b1001: begin add_x = a;        add_y = b;       end
            4'b1010: begin add_x = a | ~b;   add_y = a & b;   end
            4'b1011: begin add_x = a & b;    add_y = 4'hF;    end
            4'b1100: begin add_x = a;        add_y = a;       end
            4'b1101: begin add_x = a | b;    add_y = a;       end
            4'b1110: begin add_x = a | ~b;   add_y = a;       end
            default: begin add_x = a;        add_y = 4'hF;    end
        endcase
        sum = {1'b0, add_x} + {1'b0, add_y} + {4'b0000, c_in};
    end

    always_comb begin
        logic_f = 4'h0;
        unique case (sel)
            4'b0000: logic_f = ~a;
            4'b0001: logic_f = ~(a | b);
            4'b0010: logic_f = ~a & b;
            4'b0011: logic_f = 4'h0;
            4'b0100: logic_f = ~(a & b);
            4'b0101: logic_f = ~b;
            4'b0110: logic_f = a ^ b;
            4'b0111: logic_f = a & ~b;
            4'b1000: logic_f = ~a | b;
            4'b1001: logic_f = ~(a ^ b);
            4'b1010: logic_f = b;
            4'b1011: logic_f = a & b;
            4'b1100: logic_f = 4'hF;
            4'b1101: logic_f = a | ~b;
            4'b1110: logic_f = a | b;
            default: logic_f = a;
        endcase
    end

    assign f      = mode ? logic_f : sum[3:0];
    assign c_out  = sum[4];
    assign a_eq_b = (f == 4'hF);

endmodule

// File: rtl/module_ula_seq16.sv
// Nibble-serial W-bit ALU: one 74181 slice is reused for N_NIB cycles, least-significant nibble first.
//  state | meaning
//  IDLE  | waiting for start; operands captured on start
//  RUN   | one nibble per cycle, carry and eq chained through registers
//  DONE  | one-cycle done pulse, outputs already updated
module module_ula_seq16
    import ula_pkg::*;
#(
    parameter int N_NIB = N_NIB_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*N_NIB-1:0]   op_a,
    input  logic [4*N_NIB-1:0]   op_b,
    input  logic [3:0]           sel,
    input  logic                 mode,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*N_NIB-1:0]   result,
    output logic                 cout,
    output logic                 a_eq_b,
    output logic                 zero
);

    localparam int W  = 4 * N_NIB;
    localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [3:0]      sel_reg;
    logic            mode_reg;
    logic            carry;
    logic            eq_acc;
    logic [IW-1:0]   idx;
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_nxt;
    logic            last;
    logic [3:0]      s_f;
    logic            s_cout;
    logic            s_eq;

    module_ula_74181 u_slice (
        .a      (a_reg[4*idx +: 4]),
        .b      (b_reg[4*idx +: 4]),
        .sel    (sel_reg),
        .mode   (mode_reg),
        .c_in   (carry),
        .f      (s_f),
        .c_out  (s_cout),
        .a_eq_b (s_eq)
    );

    assign last = (idx == IW'(N_NIB - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        acc_nxt = acc;
        acc_nxt[4*idx +: 4] = s_f;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Partial nibbles collect in acc so the visible outputs only change on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sel_reg  <= '0;
            mode_reg <= 1'b0;
            carry    <= 1'b0;
            eq_acc   <= 1'b0;
            idx      <= '0;
            acc      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            a_eq_b   <= 1'b0;
            zero     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= op_a;
                        b_reg    <= op_b;
                        sel_reg  <= sel;
                        mode_reg <= mode;
                        carry    <= cin;
                        eq_acc   <= 1'b1;
                        idx      <= '0;
                        acc      <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    carry  <= s_cout;
                    eq_acc <= eq_acc & s_eq;
                    if (last) begin
                        result <= acc_nxt;
                        cout   <= s_cout;
                        a_eq_b <= eq_acc & s_eq;
                        zero   <= (acc_nxt == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_ula_seq16.sv
// Directed bench for the nibble-serial ALU: vector table plus busy/reset corner sequences.
module tb_module_ula_seq16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  sel;
    logic        mode;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        a_eq_b;
    logic        zero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sel;
        logic        mode;
        logic        cin;
        logic [15:0] res;
        logic        co;
        logic        chk_co;
        logic        eq;
        logic        z;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    module_ula_seq16 #(.N_NIB(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .sel    (sel),
        .mode   (mode),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .a_eq_b (a_eq_b),
        .zero   (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic c);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sel   = s;
        mode  = m;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the negedge index (1 = first cycle after start was sampled) of the done pulse, 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        vecs[0]  = '{16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 4'b0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{16'h5A5A, 16'hFFFF, 4'b0110, 1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{16'hABCD, 16'hABCD, 4'b0110, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'h4FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'hF0F0, 16'h3C3C, 4'b1011, 1'b1, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h1200, 16'h0034, 4'b1110, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'h1234, 16'h5678, 4'b0011, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{16'h1234, 16'h5678, 4'b0011, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{16'h0FFF, 16'h0000, 4'b1001, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{16'hF0F0, 16'h0F0F, 4'b1001, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; sel = '0; mode = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 16'h0000);
        check("reset cout", cout, 0);
        check("reset zero", zero, 0);
        check("reset a_eq_b", a_eq_b, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].mode, vecs[i].cin);
            wait_done(lat);
            check($sformatf("v%0d latency", i), lat, 5);
            check($sformatf("v%0d result", i), result, vecs[i].res);
            if (vecs[i].chk_co) check($sformatf("v%0d cout", i), cout, vecs[i].co);
            check($sformatf("v%0d a_eq_b", i), a_eq_b, vecs[i].eq);
            check($sformatf("v%0d zero", i), zero, vecs[i].z);
            check($sformatf("v%0d busy in done", i), busy, 0);
            @(negedge clk);
            check($sformatf("v%0d done width", i), done, 0);
        end

        // Start with different operands while RUN: ignored, single done pulse, first result kept.
        launch(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        @(negedge clk);
        check("busy run", busy, 1);
        @(negedge clk);
        op_a = 16'hFFFF; op_b = 16'hFFFF; sel = 4'b0000; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        lat = 0;
        for (int n = 3; n <= 12; n++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
        check("busy start pulses", pulses, 1);
        check("busy start latency", lat, 5);
        check("busy start result", result, 16'h0100);

        // Start held during the DONE cycle must not launch a new operation.
        launch(16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b0);
        wait_done(lat);
        check("done-start latency", lat, 5);
        op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done-start busy", busy, 0);
        check("done-start result", result, 16'h0003);

        // Reset in the second RUN cycle: back to IDLE, cleared, no done.
        launch(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid-run rst busy", busy, 0);
        check("mid-run rst result", result, 16'h0000);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("mid-run rst no done", pulses, 0);
        launch(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0);
        wait_done(lat);
        check("after rst latency", lat, 5);
        check("after rst result", result, 16'h2345);
        check("after rst cout", cout, 0);

        // rst and start together resolve to reset.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op_a = 16'h0001; op_b = 16'h0001;
        @(posedge clk);
        #1 begin rst = 1'b0; start = 1'b0; end
        @(negedge clk);
        check("rst+start busy", busy, 0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst+start no done", pulses, 0);
        check("rst+start result", result, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
